// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: instruction width, NOP encoding,
// default program-counter width and the fetch FSM state type.
package instruction_fetch_pkg;

  localparam int PC_W_DEFAULT = 8;
  localparam int INS_W        = 6;

  localparam logic [3:0]       OPCODE_NOP = 4'hF;
  localparam logic [INS_W-1:0] INS_NOP    = {OPCODE_NOP, 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_buffer.sv
// One-entry prefetch buffer holding an instruction and its address; only built
// into instruction_fetch when IFETCH_PREFETCH_EN is defined.
module ifetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [INS_W-1:0] push_ins,
  input  logic [PC_W-1:0]  push_pc,
  output logic             valid,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  pc
);

  logic             valid_r;
  logic [INS_W-1:0] ins_r;
  logic [PC_W-1:0]  pc_r;

  // Entry storage; a push coinciding with a pop replaces the entry.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_r <= 1'b0;
      ins_r   <= INS_NOP;
      pc_r    <= {PC_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      ins_r   <= INS_NOP;
    end else if (push) begin
      valid_r <= 1'b1;
      ins_r   <= push_ins;
      pc_r    <= push_pc;
    end else if (pop) begin
      valid_r <= 1'b0;
      ins_r   <= INS_NOP;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign ins   = ins_r;
  assign pc    = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues program-memory reads, presents instructions to the
// decoder with valid/ready and handles redirects. Define IFETCH_PREFETCH_EN for a one-entry prefetch buffer.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_addr,
  output logic             pm_req,
  output logic [PC_W-1:0]  pm_addr,
  input  logic             pm_ack,
  input  logic [INS_W-1:0] pm_data,
  output logic [INS_W-1:0] Ins,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [PC_W-1:0]  pc
);

  fetch_state_e     state_r, state_s;
  logic             pm_req_r, pm_req_s;
  logic [PC_W-1:0]  pm_addr_r, pm_addr_s;
  logic [PC_W-1:0]  jmp_tgt_r, jmp_tgt_s;
  logic [INS_W-1:0] ins_r, ins_s;
  logic             ins_valid_r, ins_valid_s;
  logic [PC_W-1:0]  pc_r, pc_s;
  logic             drop_s, room_s;
  logic             ack_s, take_s, consume_s;
  logic             buf_valid_s;
  logic [INS_W-1:0] buf_ins_s;
  logic [PC_W-1:0]  buf_pc_s;

  assign ack_s     = pm_req_r & pm_ack;
  assign take_s    = ack_s & (state_r == FETCH) & ~jmp_valid;
  assign consume_s = ins_valid_r & ins_ready;

`ifdef IFETCH_PREFETCH_EN
  logic buf_push_s, buf_pop_s, buf_flush_s;

  ifetch_buffer #(.PC_W(PC_W)) u_buf (
    .clk      (clk),
    .nReset   (nReset),
    .flush    (buf_flush_s),
    .push     (buf_push_s),
    .pop      (buf_pop_s),
    .push_ins (pm_data),
    .push_pc  (pm_addr_r),
    .valid    (buf_valid_s),
    .ins      (buf_ins_s),
    .pc       (buf_pc_s)
  );
`else
  assign buf_valid_s = 1'b0;
  assign buf_ins_s   = INS_NOP;
  assign buf_pc_s    = {PC_W{1'b0}};
`endif

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    pm_req_s    = pm_req_r;
    pm_addr_s   = pm_addr_r;
    jmp_tgt_s   = jmp_tgt_r;
    ins_s       = ins_r;
    ins_valid_s = ins_valid_r;
    pc_s        = pc_r;
    drop_s      = 1'b0;
    room_s      = 1'b0;
`ifdef IFETCH_PREFETCH_EN
    buf_push_s  = 1'b0;
    buf_pop_s   = 1'b0;
    buf_flush_s = 1'b0;
`endif
    if (jmp_valid) begin
      ins_s       = INS_NOP;
      ins_valid_s = 1'b0;
`ifdef IFETCH_PREFETCH_EN
      buf_flush_s = 1'b1;
`endif
      // An unanswered request must complete at its original address before redirecting.
      if (pm_req_r && !pm_ack) begin
        drop_s    = 1'b1;
        pm_req_s  = 1'b1;
        jmp_tgt_s = jmp_addr;
      end else begin
        pm_addr_s = jmp_addr;
        pm_req_s  = en;
      end
    end else begin
      if (!ins_valid_r || consume_s) begin
        if (buf_valid_s) begin
          ins_s       = buf_ins_s;
          pc_s        = buf_pc_s;
          ins_valid_s = 1'b1;
`ifdef IFETCH_PREFETCH_EN
          buf_pop_s   = 1'b1;
          buf_push_s  = take_s;
`endif
        end else if (take_s) begin
          ins_s       = pm_data;
          pc_s        = pm_addr_r;
          ins_valid_s = 1'b1;
        end else begin
          ins_s       = INS_NOP;
          ins_valid_s = 1'b0;
        end
      end else begin
        ins_s = ins_r;
`ifdef IFETCH_PREFETCH_EN
        buf_push_s = take_s;
`endif
      end

      if (state_r == DROP) begin
        if (ack_s) begin
          pm_addr_s = jmp_tgt_r;
          pm_req_s  = en;
        end else begin
          drop_s   = 1'b1;
          pm_req_s = 1'b1;
        end
      end else begin
        if (take_s) begin
          pm_addr_s = pm_addr_r + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
          pm_addr_s = pm_addr_r;
        end
`ifdef IFETCH_PREFETCH_EN
        room_s = ~(ins_valid_s & ((buf_valid_s & ~buf_pop_s) | buf_push_s));
`else
        room_s = ~ins_valid_s;
`endif
        if (pm_req_r && !pm_ack) begin
          pm_req_s = 1'b1;
        end else begin
          pm_req_s = en & room_s;
        end
      end
    end

    if (drop_s) begin
      state_s = DROP;
    end else if (pm_req_s) begin
      state_s = FETCH;
    end else if (ins_valid_s) begin
      state_s = HOLD;
    end else begin
      state_s = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r     <= IDLE;
      pm_req_r    <= 1'b0;
      pm_addr_r   <= RESET_PC;
      jmp_tgt_r   <= RESET_PC;
      ins_r       <= INS_NOP;
      ins_valid_r <= 1'b0;
      pc_r        <= RESET_PC;
    end else begin
      state_r     <= state_s;
      pm_req_r    <= pm_req_s;
      pm_addr_r   <= pm_addr_s;
      jmp_tgt_r   <= jmp_tgt_s;
      ins_r       <= ins_s;
      ins_valid_r <= ins_valid_s;
      pc_r        <= pc_s;
    end
  end

  assign pm_req    = pm_req_r;
  assign pm_addr   = pm_addr_r;
  assign Ins       = ins_r;
  assign ins_valid = ins_valid_r;
  assign pc        = pc_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table plus hand-written
// multi-cycle sequences, with a program-memory responder of configurable latency.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [5:0] NOP_W = 6'h3C;

  logic       clk = 1'b0;
  logic       nReset;
  logic       en, jmp_valid, ins_ready;
  logic [7:0] jmp_addr;
  logic       pm_req, pm_ack, ins_valid;
  logic [7:0] pm_addr, pc;
  logic [5:0] pm_data, Ins;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .en        (en),
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr),
    .pm_req    (pm_req),
    .pm_addr   (pm_addr),
    .pm_ack    (pm_ack),
    .pm_data   (pm_data),
    .Ins       (Ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .pc        (pc)
  );

  typedef struct {
    logic       en;
    logic       rdy;
    logic       jmp;
    logic [7:0] ja;
    logic       req;
    logic [7:0] addr;
    logic       iv;
    logic [5:0] ins;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [5:0] mem_word(input logic [7:0] a);
    logic [15:0] v;
    v = 16'(a) * 16'd7 + 16'(a[7:6]) * 16'd13 + 16'd5;
    return v[5:0];
  endfunction

  function automatic vec_t mk(input logic e, input logic r, input logic j, input logic [7:0] ja,
                              input logic req, input logic [7:0] addr, input logic iv,
                              input logic [5:0] ins, input logic [7:0] p);
    vec_t v;
    v.en = e; v.rdy = r; v.jmp = j; v.ja = ja;
    v.req = req; v.addr = addr; v.iv = iv; v.ins = ins; v.pc = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, let the memory model answer, advance one clock, settle past the edge.
  task automatic cycle(input logic e, input logic r, input logic j, input logic [7:0] ja);
    en = e; ins_ready = r; jmp_valid = j; jmp_addr = ja;
    if (pm_req) begin
      if (wait_cnt >= lat) begin
        pm_ack = 1'b1; pm_data = mem_word(pm_addr); wait_cnt = 0;
      end else begin
        pm_ack = 1'b0; pm_data = 6'h00; wait_cnt++;
      end
    end else begin
      pm_ack = 1'b0; pm_data = 6'h00; wait_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; en = 1'b0; jmp_valid = 1'b0; jmp_addr = 8'h00;
    ins_ready = 1'b0; pm_ack = 1'b0; pm_data = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset pm_req", pm_req, 1'b0);
    check("reset pm_addr", pm_addr, 8'h00);
    check("reset ins_valid", ins_valid, 1'b0);
    check("reset Ins", Ins, NOP_W);
    check("reset pc", pc, 8'h00);
    nReset = 1'b1;

`ifndef IFETCH_PREFETCH_EN
    //                 en    rdy   jmp   ja     req   addr   iv    ins            pc
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, NOP_W,         8'h00);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, NOP_W,         8'h00);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 6'h05,         8'h00);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, NOP_W,         8'h00);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, NOP_W,         8'h00);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 6'h0C,         8'h01);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, NOP_W,         8'h01);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, NOP_W,         8'h01);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 6'h13,         8'h02);
    for (int k = 9; k <= 13; k++) begin
      vecs[k] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 6'h13,        8'h02);
    end
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, NOP_W,         8'h02);
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 8'h03, 1'b0, NOP_W,         8'h02);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, NOP_W,         8'h02);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, NOP_W,         8'h02);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 6'h12,         8'h40);
    vecs[19] = mk(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, NOP_W,         8'h40);
    vecs[20] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, NOP_W,         8'h40);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 6'h25,         8'hFF);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, NOP_W,         8'hFF);

    lat = 1;
    for (int i = 0; i < 23; i++) begin
      cycle(vecs[i].en, vecs[i].rdy, vecs[i].jmp, vecs[i].ja);
      check($sformatf("vec%0d pm_req", i), pm_req, vecs[i].req);
      check($sformatf("vec%0d ins_valid", i), ins_valid, vecs[i].iv);
      check($sformatf("vec%0d Ins", i), Ins, vecs[i].ins);
      if (vecs[i].req) begin
        check($sformatf("vec%0d pm_addr", i), pm_addr, vecs[i].addr);
      end else begin
        n_checks = n_checks;
      end
      if (vecs[i].iv) begin
        check($sformatf("vec%0d pc", i), pc, vecs[i].pc);
      end else begin
        n_checks = n_checks;
      end
    end

    // Jump arriving in the same cycle as the memory acknowledge.
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'h20);
    check("jmp+ack ins_valid", ins_valid, 1'b0);
    check("jmp+ack pm_addr", pm_addr, 8'h20);
    check("jmp+ack pm_req", pm_req, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("jmp+ack Ins", Ins, mem_word(8'h20));
    check("jmp+ack pc", pc, 8'h20);
    check("jmp+ack valid", ins_valid, 1'b1);

    // Enable dropping while a request is outstanding.
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("en-fall req issued", pm_req, 1'b1);
    check("en-fall req addr", pm_addr, 8'h21);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("en-fall req kept", pm_req, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("en-fall data valid", ins_valid, 1'b1);
    check("en-fall data Ins", Ins, mem_word(8'h21));
    check("en-fall no new req", pm_req, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("en-fall held valid", ins_valid, 1'b1);
    check("en-fall held pc", pc, 8'h21);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("en-fall idle valid", ins_valid, 1'b0);
    check("en-fall idle Ins", Ins, NOP_W);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("en-fall idle req", pm_req, 1'b0);
`else
    // Zero-wait memory with the prefetch buffer: one instruction every cycle after fill.
    lat = 0;
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("pf first req", pm_req, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      check($sformatf("pf%0d ins_valid", k), ins_valid, 1'b1);
      check($sformatf("pf%0d Ins", k), Ins, mem_word(8'(k)));
      check($sformatf("pf%0d pc", k), pc, 32'(k));
    end
    lat = 1;
`endif

    // Asynchronous reset while a fetch is in flight.
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("pre-reset req", pm_req, 1'b1);
    #2;
    nReset = 1'b0;
    #1;
    check("async reset pm_req", pm_req, 1'b0);
    check("async reset pc", pc, 8'h00);
    check("async reset Ins", Ins, NOP_W);
    check("async reset pm_addr", pm_addr, 8'h00);
    check("async reset ins_valid", ins_valid, 1'b0);
    pm_ack = 1'b1;
    pm_data = 6'h2A;
    @(posedge clk);
    #1;
    check("in-reset ack ignored", ins_valid, 1'b0);
    check("in-reset req", pm_req, 1'b0);
    nReset = 1'b1;
    pm_ack = 1'b0;
    wait_cnt = 0;
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("post-reset idle req", pm_req, 1'b0);
    check("post-reset idle Ins", Ins, NOP_W);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
